// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one UART transmitter,
// optionally prefixing each data byte with a tag byte that identifies the requester.
module uart_tx_arbiter #(
  parameter bit         TAG_EN   = 1'b0,
  parameter logic [7:0] TAG_BASE = 8'hA0
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic [3:0]  i_Req_DV,
  input  logic [31:0] i_Req_Byte,
  output logic [3:0]  o_Req_Ack,
  output logic [3:0]  o_Req_Done,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Active,
  input  logic        i_Tx_Done,
  output logic        o_Busy,
  output logic [1:0]  o_Grant_Id
);

  typedef enum logic [2:0] {
    IDLE, ARB, SEND_TAG, WAIT_TAG, SEND_DATA, WAIT_DATA, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  grant_id;
  logic [1:0]  rr_start;
  logic [1:0]  win_id;
  logic [1:0]  search_id;
  logic        win_found;
  logic [7:0]  data_byte;
  logic [7:0]  tag_byte;
  logic        tx_done_d;
  logic        done_rise;
  logic        tx_ready;

  assign tag_byte   = {TAG_BASE[7:2], grant_id};
  assign done_rise  = i_Tx_Done && !tx_done_d;
  assign tx_ready   = !i_Tx_Active && !i_Tx_Done;
  assign o_Grant_Id = grant_id;

  // Scanning from the farthest offset down leaves the nearest requester as the winner.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_start;
    search_id = rr_start;
    for (int i = 3; i >= 0; i--) begin
      search_id = rr_start + 2'(i);
      if (i_Req_DV[search_id]) begin
        win_found = 1'b1;
        win_id    = search_id;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= IDLE;
      grant_id  <= 2'd0;
      rr_start  <= 2'd0;
      data_byte <= 8'h00;
      tx_done_d <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_done_d <= i_Tx_Done;
      if (state == ARB && win_found) begin
        grant_id  <= win_id;
        rr_start  <= win_id + 2'd1;
        data_byte <= i_Req_Byte[{win_id, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    o_Req_Ack  = 4'b0000;
    o_Req_Done = 4'b0000;
    o_Tx_DV    = 1'b0;
    o_Tx_Byte  = 8'h00;
    o_Busy     = 1'b0;
    case (state)
      IDLE: begin
        if (|i_Req_DV) state_nxt = ARB;
      end
      // A requester that dropped DV since IDLE leaves nobody to grant.
      ARB: begin
        if (win_found) begin
          o_Req_Ack[win_id] = 1'b1;
          o_Busy            = 1'b1;
          state_nxt         = TAG_EN ? SEND_TAG : SEND_DATA;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND_TAG: begin
        o_Busy = 1'b1;
        if (tx_ready) begin
          o_Tx_DV   = 1'b1;
          o_Tx_Byte = tag_byte;
          state_nxt = WAIT_TAG;
        end
      end
      WAIT_TAG: begin
        o_Busy = 1'b1;
        if (done_rise) state_nxt = SEND_DATA;
      end
      SEND_DATA: begin
        o_Busy = 1'b1;
        if (tx_ready) begin
          o_Tx_DV   = 1'b1;
          o_Tx_Byte = data_byte;
          state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        o_Busy = 1'b1;
        if (done_rise) state_nxt = DONE;
      end
      DONE: begin
        o_Busy               = 1'b1;
        o_Req_Done[grant_id] = 1'b1;
        state_nxt            = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (tag off / tag on) share one
// 4-clocks-per-bit transmitter model selected by sel.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  req_dv = 4'b0000;
  logic [31:0] req_byte = 32'h0;
  int          done_hold = 1;
  int          errors = 0;
  int          checks = 0;

  logic [3:0] dv0, dv1, ack0, ack1, done0, done1;
  logic       txdv0, txdv1, busy0, busy1;
  logic [7:0] txb0, txb1;
  logic [1:0] gid0, gid1;
  logic [3:0] m_ack, m_done;
  logic       m_tx_dv, m_busy;
  logic [7:0] m_tx_byte;
  logic [1:0] m_grant;

  logic       tx_active = 1'b0;
  logic       tx_done;
  logic       serial = 1'b1;
  logic [9:0] frame = 10'h3FF;
  int         bit_idx = 0;
  int         clk_cnt = 0;
  int         done_cnt = 0;
  int         frames_done = 0;

  logic [7:0] tx_log[$];
  logic [7:0] rx_log[$];
  int         ack_log[$];
  int         ack_cnt[4] = '{0, 0, 0, 0};
  int         rq_done_cnt[4] = '{0, 0, 0, 0};
  int         txdv_cnt = 0;
  int         gate_err = 0;
  int         consec_err = 0;
  int         order_err = 0;
  logic       prev_ack = 1'b0, prev_done = 1'b0, prev_txdv = 1'b0;
  logic       seen_txd = 1'b0;

  assign dv0 = sel ? 4'b0000 : req_dv;
  assign dv1 = sel ? req_dv : 4'b0000;
  assign m_ack     = sel ? ack1  : ack0;
  assign m_done    = sel ? done1 : done0;
  assign m_tx_dv   = sel ? txdv1 : txdv0;
  assign m_tx_byte = sel ? txb1  : txb0;
  assign m_busy    = sel ? busy1 : busy0;
  assign m_grant   = sel ? gid1  : gid0;
  assign tx_done   = (done_cnt != 0);

  uart_tx_arbiter #(.TAG_EN(1'b0), .TAG_BASE(8'hA0)) dut0 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_DV(dv0), .i_Req_Byte(req_byte),
    .o_Req_Ack(ack0), .o_Req_Done(done0), .o_Tx_DV(txdv0), .o_Tx_Byte(txb0),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .o_Busy(busy0), .o_Grant_Id(gid0));

  uart_tx_arbiter #(.TAG_EN(1'b1), .TAG_BASE(8'hA0)) dut1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_DV(dv1), .i_Req_Byte(req_byte),
    .o_Req_Ack(ack1), .o_Req_Done(done1), .o_Tx_DV(txdv1), .o_Tx_Byte(txb1),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .o_Busy(busy1), .o_Grant_Id(gid1));

  always #5 clk = ~clk;

  // Transmitter model: start bit, 8 data bits LSB first, stop bit, then done for done_hold cycles.
  always @(posedge clk) begin
    if (done_cnt != 0) done_cnt <= done_cnt - 1;
    if (!tx_active) begin
      if (m_tx_dv) begin
        tx_active <= 1'b1;
        frame     <= {1'b1, m_tx_byte, 1'b0};
        bit_idx   <= 0;
        clk_cnt   <= 0;
        serial    <= 1'b0;
      end
    end else if (clk_cnt == 3) begin
      clk_cnt <= 0;
      if (bit_idx == 9) begin
        tx_active   <= 1'b0;
        serial      <= 1'b1;
        done_cnt    <= done_hold;
        frames_done <= frames_done + 1;
      end else begin
        bit_idx <= bit_idx + 1;
        serial  <= frame[bit_idx + 1];
      end
    end else begin
      clk_cnt <= clk_cnt + 1;
    end
  end

  initial begin : receiver
    logic [7:0] rx_byte;
    rx_byte = 8'h00;
    forever begin
      @(negedge serial);
      repeat (2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(posedge clk);
        rx_byte[i] = serial;
      end
      rx_log.push_back(rx_byte);
    end
  end

  always @(negedge clk) begin
    if (m_tx_dv) begin
      tx_log.push_back(m_tx_byte);
      txdv_cnt++;
      if (tx_active || tx_done) gate_err++;
      seen_txd = 1'b0;
    end
    if (tx_done) seen_txd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_ack[i]) begin
        ack_cnt[i]++;
        ack_log.push_back(i);
      end
      if (m_done[i]) rq_done_cnt[i]++;
    end
    if (m_done != 4'b0000 && !seen_txd) order_err++;
    if ((m_ack != 4'b0000 && prev_ack) || (m_done != 4'b0000 && prev_done) || (m_tx_dv && prev_txdv))
      consec_err++;
    prev_ack  = (m_ack != 4'b0000);
    prev_done = (m_done != 4'b0000);
    prev_txdv = m_tx_dv;
  end

  task automatic do_reset(input logic use_tag);
    @(negedge clk);
    rst_n  = 1'b0;
    req_dv = 4'b0000;
    sel    = use_tag;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drops each acked DV one cycle after its ack (never inside the ARB cycle).
  task automatic serve(input int n_acks, input int n_dones, input bit hold, output bit ok);
    int a, d;
    logic [3:0] pending;
    a = 0; d = 0; ok = 1'b0; pending = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req_dv  = req_dv & ~pending;
      pending = 4'b0000;
      if (m_ack != 4'b0000) begin
        a++;
        if (!hold) pending = m_ack;
        else if (a >= n_acks) pending = 4'b1111;
      end
      if (m_done != 4'b0000) d++;
      if (a >= n_acks && d >= n_dones) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    req_dv = req_dv & ~pending;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (m_ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b want 0000", m_ack); end
    checks++; if (m_done !== 4'b0000) begin errors++; $display("[TB] FAIL reset_done: got %b want 0000", m_done); end
    checks++; if (m_tx_dv !== 1'b0) begin errors++; $display("[TB] FAIL reset_txdv: got %b want 0", m_tx_dv); end
    checks++; if (m_tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_txbyte: got %h want 00", m_tx_byte); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", m_busy); end
    checks++; if (m_grant !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant: got %0d want 0", m_grant); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int a0, d0, t0, r0;
    bit ok;
    a0 = ack_cnt[2]; d0 = rq_done_cnt[2]; t0 = txdv_cnt; r0 = rx_log.size();
    req_byte[23:16] = 8'h5A;
    req_dv[2] = 1'b1;
    serve(1, 1, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_timeout: got %b want 1", ok); end
    checks++; if (ack_cnt[2] - a0 !== 1) begin errors++; $display("[TB] FAIL single_ack2: got %0d want 1", ack_cnt[2] - a0); end
    checks++; if (txdv_cnt - t0 !== 1) begin errors++; $display("[TB] FAIL single_txdv: got %0d want 1", txdv_cnt - t0); end
    checks++; if (tx_log[$] !== 8'h5A) begin errors++; $display("[TB] FAIL single_txbyte: got %h want 5a", tx_log[$]); end
    checks++; if (rx_log.size() - r0 !== 1 || rx_log[$] !== 8'h5A) begin errors++; $display("[TB] FAIL single_serial: got %h want 5a", rx_log[$]); end
    checks++; if (rq_done_cnt[2] - d0 !== 1) begin errors++; $display("[TB] FAIL single_done2: got %0d want 1", rq_done_cnt[2] - d0); end
    checks++; if (m_grant !== 2'd2) begin errors++; $display("[TB] FAIL single_grant: got %0d want 2", m_grant); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_after: got %b want 0", m_busy); end
  endtask

  task automatic test_round_robin;
    int s0, g0;
    bit ok;
    logic [7:0] exp_b;
    do_reset(1'b0);
    s0 = tx_log.size(); g0 = gate_err;
    req_byte = 32'h13121110;
    req_dv   = 4'b1111;
    serve(8, 8, 1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rr_timeout: got %b want 1", ok); end
    checks++; if (tx_log.size() - s0 !== 8) begin errors++; $display("[TB] FAIL rr_count: got %0d want 8", tx_log.size() - s0); end
    for (int k = 0; k < 8; k++) begin
      exp_b = 8'h10 + 8'(k % 4);
      if (s0 + k < tx_log.size()) begin
        checks++;
        if (tx_log[s0 + k] !== exp_b) begin errors++; $display("[TB] FAIL rr_order%0d: got %h want %h", k, tx_log[s0 + k], exp_b); end
      end
    end
    checks++; if (gate_err - g0 !== 0) begin errors++; $display("[TB] FAIL rr_gating: got %0d want 0", gate_err - g0); end
  endtask

  task automatic test_tag;
    int a0, d0, t0, s0, r0;
    bit ok;
    do_reset(1'b1);
    a0 = ack_cnt[1]; d0 = rq_done_cnt[1]; t0 = txdv_cnt; s0 = tx_log.size(); r0 = rx_log.size();
    req_byte[15:8] = 8'h3C;
    req_dv[1] = 1'b1;
    serve(1, 1, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL tag_timeout: got %b want 1", ok); end
    checks++; if (txdv_cnt - t0 !== 2) begin errors++; $display("[TB] FAIL tag_txdv: got %0d want 2", txdv_cnt - t0); end
    checks++; if (tx_log.size() - s0 !== 2 || tx_log[s0] !== 8'hA1 || tx_log[s0 + 1] !== 8'h3C)
      begin errors++; $display("[TB] FAIL tag_stream: got %h %h want a1 3c", tx_log[s0], tx_log[$]); end
    checks++; if (rx_log.size() - r0 !== 2 || rx_log[r0] !== 8'hA1 || rx_log[$] !== 8'h3C)
      begin errors++; $display("[TB] FAIL tag_serial: got %h %h want a1 3c", rx_log[r0], rx_log[$]); end
    checks++; if (ack_cnt[1] - a0 !== 1) begin errors++; $display("[TB] FAIL tag_ack1: got %0d want 1", ack_cnt[1] - a0); end
    checks++; if (rq_done_cnt[1] - d0 !== 1) begin errors++; $display("[TB] FAIL tag_done1: got %0d want 1", rq_done_cnt[1] - d0); end
  endtask

  task automatic test_priority;
    int l0, s0;
    bit ok;
    do_reset(1'b0);
    l0 = ack_log.size(); s0 = tx_log.size();
    req_byte = 32'h33000040;
    req_dv[3] = 1'b1;
    serve(1, 0, 1'b0, ok);
    repeat (8) @(negedge clk);
    req_byte = 32'h34000040;
    req_dv   = 4'b1001;
    serve(2, 3, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL prio_timeout: got %b want 1", ok); end
    checks++; if (ack_log.size() - l0 !== 3 || ack_log[l0] !== 3 || ack_log[l0 + 1] !== 0 || ack_log[l0 + 2] !== 3)
      begin errors++; $display("[TB] FAIL prio_grant_order: got %0d acks, second id %0d want 3,0,3", ack_log.size() - l0, ack_log[l0 + 1]); end
    checks++; if (tx_log.size() - s0 !== 3 || tx_log[s0] !== 8'h33 || tx_log[s0 + 1] !== 8'h40 || tx_log[s0 + 2] !== 8'h34)
      begin errors++; $display("[TB] FAIL prio_bytes: got %h %h want 33 40 34", tx_log[s0], tx_log[$]); end
  endtask

  task automatic test_reset_mid;
    int d0, f0, dr;
    bit ok, got_dv;
    logic [3:0] pending;
    do_reset(1'b0);
    req_byte[23:16] = 8'h77;
    req_dv[2] = 1'b1;
    serve(1, 0, 1'b0, ok);
    repeat (10) @(negedge clk);
    d0 = rq_done_cnt[2]; f0 = frames_done;
    rst_n = 1'b0;
    req_byte[23:16] = 8'h78;
    req_dv[2] = 1'b1;
    @(negedge clk);
    checks++; if (m_busy !== 1'b0 || m_grant !== 2'd0 || m_tx_dv !== 1'b0)
      begin errors++; $display("[TB] FAIL mid_reset_outputs: got busy=%b grant=%0d txdv=%b want 0 0 0", m_busy, m_grant, m_tx_dv); end
    checks++; if (m_ack !== 4'b0000 || m_done !== 4'b0000 || m_tx_byte !== 8'h00)
      begin errors++; $display("[TB] FAIL mid_reset_pulses: got ack=%b done=%b byte=%h want 0", m_ack, m_done, m_tx_byte); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dr = rq_done_cnt[2];
    checks++; if (dr - d0 !== 0) begin errors++; $display("[TB] FAIL mid_reset_no_done: got %0d want 0", dr - d0); end
    got_dv = 1'b0; pending = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req_dv = req_dv & ~pending;
      pending = m_ack;
      if (m_tx_dv) begin
        got_dv = 1'b1;
        break;
      end
    end
    checks++; if (got_dv !== 1'b1) begin errors++; $display("[TB] FAIL mid_new_txdv_timeout: got %b want 1", got_dv); end
    checks++; if (frames_done - f0 < 1 || tx_active !== 1'b0 || tx_done !== 1'b0)
      begin errors++; $display("[TB] FAIL mid_txdv_too_early: got frames=%0d active=%b done=%b want >=1 0 0", frames_done - f0, tx_active, tx_done); end
    checks++; if (m_tx_byte !== 8'h78) begin errors++; $display("[TB] FAIL mid_new_byte: got %h want 78", m_tx_byte); end
    @(negedge clk);
    req_dv = req_dv & ~pending;
    serve(0, 1, 1'b0, ok);
    checks++; if (rq_done_cnt[2] - d0 !== 1) begin errors++; $display("[TB] FAIL mid_done_total: got %0d want 1", rq_done_cnt[2] - d0); end
  endtask

  task automatic test_done_hold;
    int a0, d0, t0, s0;
    bit ok;
    done_hold = 2;
    do_reset(1'b1);
    a0 = ack_cnt[0]; d0 = rq_done_cnt[0]; t0 = txdv_cnt; s0 = tx_log.size();
    req_byte[7:0] = 8'h5C;
    req_dv[0] = 1'b1;
    serve(1, 1, 1'b0, ok);
    repeat (20) @(negedge clk);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL hold_timeout: got %b want 1", ok); end
    checks++; if (txdv_cnt - t0 !== 2 || tx_log[s0] !== 8'hA0 || tx_log[$] !== 8'h5C)
      begin errors++; $display("[TB] FAIL hold_stream: got %0d bytes %h %h want 2 a0 5c", txdv_cnt - t0, tx_log[s0], tx_log[$]); end
    checks++; if (ack_cnt[0] - a0 !== 1) begin errors++; $display("[TB] FAIL hold_ack0: got %0d want 1", ack_cnt[0] - a0); end
    checks++; if (rq_done_cnt[0] - d0 !== 1) begin errors++; $display("[TB] FAIL hold_done0: got %0d want 1", rq_done_cnt[0] - d0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_tag;
    test_priority;
    test_reset_mid;
    test_done_hold;
    checks++; if (gate_err !== 0) begin errors++; $display("[TB] FAIL global_gating: got %0d want 0", gate_err); end
    checks++; if (consec_err !== 0) begin errors++; $display("[TB] FAIL global_consecutive: got %0d want 0", consec_err); end
    checks++; if (order_err !== 0) begin errors++; $display("[TB] FAIL global_done_order: got %0d want 0", order_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TAG_EN, default 0: 1 = send a tag byte (TAG_BASE | requester id) before each data byte.
REQ-002 Parameter TAG_BASE, default 8'hA0: tag byte base value; bits [1:0] are replaced by the requester id.
REQ-003 i_Clock  input  1  single system clock; all logic on its rising edge.
REQ-004 i_Rst_L  input  1  asynchronous active-low reset.
REQ-005 i_Req_DV  input  4  per-requester byte-valid; held high until acked.
REQ-006 i_Req_Byte  input  32  packed bytes; requester n uses bits [8n+7:8n].
REQ-007 o_Req_Ack  output  4  one-cycle pulse: requester's byte latched; requester may drop DV or present its next byte.
REQ-008 o_Req_Done  output  4  one-cycle pulse: requester's data byte fully serialized.
REQ-009 o_Tx_DV  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 o_Tx_Byte  output  8  byte to the transmitter; valid while o_Tx_DV is high.
REQ-011 i_Tx_Active  input  1  transmitter busy.
REQ-012 i_Tx_Done  input  1  transmitter done flag; may stay high for more than one cycle.
REQ-013 o_Busy  output  1  high from grant until the Done pulse.
REQ-014 o_Grant_Id  output  2  id of the current/last granted requester.

Function
REQ-015 States: IDLE, ARB, SEND_TAG, WAIT_TAG, SEND_DATA, WAIT_DATA, DONE.
REQ-016 IDLE -> ARB when any i_Req_DV bit is high.
REQ-017 ARB: round-robin; search starts at (last grant + 1) mod 4; the first requester with DV high wins.
- Latch its byte; set o_Grant_Id.
- Pulse o_Req_Ack[id] in the same cycle.
- Go to SEND_TAG if TAG_EN, else SEND_DATA.
REQ-018 SEND_TAG/SEND_DATA: assert o_Tx_DV for exactly one cycle, only in a cycle where i_Tx_Active==0 and i_Tx_Done==0; otherwise wait in the state.
- o_Tx_Byte = tag (SEND_TAG) or latched byte (SEND_DATA).
- Next state: WAIT_TAG or WAIT_DATA.
REQ-019 WAIT_*: advance on a rising edge of i_Tx_Done (high now, low on the previous cycle).
- WAIT_TAG -> SEND_DATA.
- WAIT_DATA -> DONE.
REQ-020 DONE: pulse o_Req_Done[id] for one cycle; -> IDLE.
REQ-021 Back-to-back requests: the next grant takes effect no earlier than 2 cycles after DONE.
- o_Tx_DV is gated by REQ-018, so the transmitter's done-clear interval is always respected.
REQ-022 Each requester receives at most one ack per transaction; DV from the granted requester during WAIT states is ignored until the next ARB.
REQ-023 Fairness: with all 4 DV high continuously, grant order is 0,1,2,3,0,…; no requester waits for more than 3 other transactions.
REQ-024 o_Tx_DV, o_Req_Ack and o_Req_Done are never high for two consecutive cycles.
REQ-025 A requester dropping DV before ack is legal; it is simply not granted.
REQ-026 Tag value: TAG_BASE with bits [1:0] replaced by the id.

Reset
REQ-027 While i_Rst_L is low, asynchronously:
- state = IDLE.
- All outputs 0: o_Req_Ack, o_Req_Done, o_Tx_DV, o_Tx_Byte, o_Busy, o_Grant_Id.
- Round-robin pointer set so the first search starts at requester 0.
- Done-edge register = 0.
REQ-028 Reset mid-transaction abandons the byte without any Done pulse; after release the block waits for i_Tx_Active==0 and i_Tx_Done==0 before issuing any o_Tx_DV.

Verification
REQ-029 TAG_EN=0, requester 2 sends 8'h5A, 4 clocks/bit transmitter model:
- Ack[2] pulses once.
- One o_Tx_DV with byte 5A.
- Serial line shows 5A.
- Done[2] pulses once, after the transmitter's done.
REQ-030 All 4 DV high, bytes 10/11/12/13, held for 8 transactions: transmitted order 10,11,12,13,10,11,12,13; no o_Tx_DV while Active or Done is high.
REQ-031 TAG_EN=1, requester 1 sends 8'h3C: stream is A1 then 3C; a single Ack[1] and a single Done[1].
REQ-032 Requester 3 active and requester 0 raises DV during WAIT_DATA: requester 0 is served next; requester 3's re-raised DV waits its turn.
REQ-033 i_Rst_L low during WAIT_DATA, released 3 cycles later:
- All outputs 0; no Done pulse.
- The first new o_Tx_DV is issued only after the transmitter's Active and Done are both low.
REQ-034 Transmitter Done held high for 2 cycles: the FSM advances exactly once per done; no double Done pulses.
